piso_share_ctrl: RTL and testbench

//  Sequencer and round-robin arbiter for one shared 4-bit parallel-load shift register (PISO).
//  Up to N_REQ requesters each offer a WIDTH-bit word.
//  The block grants one requester, drives the register's load/shift controls and data for a

---
 rtl/piso_share_ctrl_pkg.sv | 27 ++
 rtl/piso_share_ctrl_rr_arbiter.sv | 37 +++
 rtl/piso_share_ctrl.sv | 147 ++++++++++++++
 tb/tb_piso_share_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_share_ctrl_pkg.sv
// Shared types and sizing helpers for the PISO share controller.
// Contents:
//   state_t    FSM state encoding {IDLE, LOAD, SHIFT, GAP}
//   cnt_bits   width needed to hold 0..n (never less than 1)
//   ptr_bits   width needed to index n requesters (never less than 1)
package piso_share_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } state_t;

    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int unsigned ptr_bits(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Sizes for the default configuration (WIDTH=4, GAP_CYCLES=1).
    localparam int unsigned CNT_W = cnt_bits(4);
    localparam int unsigned GAP_W = cnt_bits(1);

endpackage

// File: rtl/piso_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr and walks upward, wrapping modulo N_REQ; the first
// asserted request found wins.
// Ports:
//   req     in   N_REQ   request vector
//   ptr     in   PTR_W   index with highest priority this round
//   winner  out  N_REQ   one-hot winner (zero when no request)
//   valid   out  1       at least one request present
module rr_arbiter
    import piso_share_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = ptr_bits(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    always_comb begin
        int unsigned idx;
        winner = '0;
        valid  = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!valid && req[idx[PTR_W-1:0]]) begin
                winner[idx[PTR_W-1:0]] = 1'b1;
                valid                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/piso_share_ctrl.sv
// Sequencer and round-robin arbiter for one shared parallel-load shift register.
// Grants one requester at a time, drives the PISO load/shift strobes and data
// for a full WIDTH-bit serialisation, then pulses done to that requester.
// Ports:
//   clk       in   1             clock
//   rst       in   1             synchronous reset, active-high
//   req       in   N_REQ         request level per requester, held until done
//   req_data  in   N_REQ*WIDTH   word of requester i at [i*WIDTH +: WIDTH]
//   gnt       out  N_REQ         one-hot grant, LOAD through last SHIFT cycle
//   done      out  N_REQ         one-cycle pulse in the final SHIFT cycle
//   sr_load   out  1             parallel-load strobe to the PISO
//   sr_shift  out  1             shift enable to the PISO
//   sr_d      out  WIDTH         parallel data to the PISO
//   busy      out  1             high whenever the FSM is not IDLE
module piso_share_ctrl
    import piso_share_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   sr_load,
    output logic                   sr_shift,
    output logic [WIDTH-1:0]       sr_d,
    output logic                   busy
);

    localparam int unsigned PTR_W   = ptr_bits(N_REQ);
    localparam int unsigned BCNT_W  = cnt_bits(WIDTH);
    localparam int unsigned GCNT_W  = cnt_bits(GAP_CYCLES);
    localparam int unsigned PEN_INT = (WIDTH >= 2) ? WIDTH - 2 : 0;
    localparam int unsigned GAP_END = (GAP_CYCLES >= 1) ? GAP_CYCLES - 1 : 0;

    localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(N_REQ - 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WIDTH - 1);
    localparam logic [BCNT_W-1:0] PEN_BIT  = BCNT_W'(PEN_INT);
    localparam logic [GCNT_W-1:0] LAST_GAP = GCNT_W'(GAP_END);

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [BCNT_W-1:0]  bit_cnt;
    logic [GCNT_W-1:0]  gap_cnt;

    logic [N_REQ-1:0]   arb_win;
    logic               arb_valid;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [WIDTH-1:0]   win_data;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (arb_win),
        .valid  (arb_valid)
    );

    // Index and data of the one-hot winner.
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_win[i]) begin
                win_idx  = i[PTR_W-1:0];
                win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
        next_ptr = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    end

    // done is registered, so it is raised on the edge that enters the final
    // SHIFT cycle: from LOAD when WIDTH is 1, otherwise from the
    // second-to-last SHIFT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            done     <= '0;
            sr_load  <= 1'b0;
            sr_shift <= 1'b0;
            sr_d     <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        state   <= LOAD;
                        gnt     <= arb_win;
                        sr_d    <= win_data;
                        rr_ptr  <= next_ptr;
                        sr_load <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    state    <= SHIFT;
                    sr_load  <= 1'b0;
                    sr_shift <= 1'b1;
                    bit_cnt  <= '0;
                    done     <= (WIDTH == 1) ? gnt : '0;
                end
                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        sr_shift <= 1'b0;
                        done     <= '0;
                        gnt      <= '0;
                        bit_cnt  <= '0;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        done    <= (bit_cnt == PEN_BIT) ? gnt : '0;
                    end
                end
                GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_share_ctrl.sv
// Directed bench for piso_share_ctrl: one instance with GAP_CYCLES=1 and one
// with GAP_CYCLES=0. Outputs are sampled 1 time unit after the rising edge.
module tb_piso_share_ctrl;

    logic        clk;
    logic        rst;

    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        sr_load;
    logic        sr_shift;
    logic [3:0]  sr_d;
    logic        busy;

    logic [3:0]  b_req;
    logic [15:0] b_req_data;
    logic [3:0]  b_gnt;
    logic [3:0]  b_done;
    logic        b_sr_load;
    logic        b_sr_shift;
    logic [3:0]  b_sr_d;
    logic        b_busy;

    int vectors;
    int miscompares;

    piso_share_ctrl #(
        .N_REQ      (4),
        .WIDTH      (4),
        .GAP_CYCLES (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .sr_load  (sr_load),
        .sr_shift (sr_shift),
        .sr_d     (sr_d),
        .busy     (busy)
    );

    piso_share_ctrl #(
        .N_REQ      (4),
        .WIDTH      (4),
        .GAP_CYCLES (0)
    ) dut_nogap (
        .clk      (clk),
        .rst      (rst),
        .req      (b_req),
        .req_data (b_req_data),
        .gnt      (b_gnt),
        .done     (b_done),
        .sr_load  (b_sr_load),
        .sr_shift (b_sr_shift),
        .sr_d     (b_sr_d),
        .busy     (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {gnt, done, sr_load, sr_shift, sr_d, busy} for cycle k of a
    // transfer (k=0 is the LOAD cycle) granted to one-hot g with data d.
    function automatic logic [14:0] exp_vec(input logic [3:0] g, input logic [3:0] d,
                                            input int k, input int gap);
        logic [3:0] eg;
        logic [3:0] ed;
        logic       ld;
        logic       sh;
        logic       bz;
        eg = g;
        ed = 4'd0;
        ld = 1'b0;
        sh = 1'b0;
        bz = 1'b1;
        if (k == 0) begin
            ld = 1'b1;
        end else if (k <= 4) begin
            sh = 1'b1;
            if (k == 4) ed = g;
        end else begin
            eg = 4'd0;
            if (k - 5 >= gap) bz = 1'b0;
        end
        return {eg, ed, ld, sh, d, bz};
    endfunction

    task automatic monitor();
        int   shcnt;
        logic armed;
        shcnt = 0;
        armed = 1'b0;
        forever begin
            @(negedge clk);
            vectors++;
            if ((gnt & (gnt - 4'd1)) !== 4'd0) begin
                miscompares++;
                $display("FAIL onehot_gnt: got %b required one-hot or zero", gnt);
            end
            vectors++;
            if ((b_gnt & (b_gnt - 4'd1)) !== 4'd0) begin
                miscompares++;
                $display("FAIL onehot_gnt_nogap: got %b required one-hot or zero", b_gnt);
            end
            vectors++;
            if ((sr_load & sr_shift) !== 1'b0) begin
                miscompares++;
                $display("FAIL load_shift_excl: load=%b shift=%b required not both", sr_load, sr_shift);
            end
            vectors++;
            if ((b_sr_load & b_sr_shift) !== 1'b0) begin
                miscompares++;
                $display("FAIL load_shift_excl_nogap: load=%b shift=%b required not both",
                         b_sr_load, b_sr_shift);
            end
            if (rst) begin
                armed = 1'b0;
                shcnt = 0;
            end else if (sr_load) begin
                if (armed) begin
                    vectors++;
                    if (shcnt !== 4) begin
                        miscompares++;
                        $display("FAIL shifts_per_load: got %0d required 4", shcnt);
                    end
                end
                armed = 1'b1;
                shcnt = 0;
            end else if (sr_shift) begin
                shcnt++;
            end
        end
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        obs = {gnt, done, sr_load, sr_shift, sr_d, busy};
        vectors++;
        if (obs !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h required %h", obs, 15'd0);
        end
        obs = {b_gnt, b_done, b_sr_load, b_sr_shift, b_sr_d, b_busy};
        vectors++;
        if (obs !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_state_nogap: got %h required %h", obs, 15'd0);
        end
    endtask

    task automatic test_contention();
        logic [3:0]  dv [4];
        logic [14:0] obs;
        logic [14:0] exp;
        int          g;
        dv = '{4'hA, 4'h6, 4'h9, 4'hC};
        req      = 4'b1111;
        req_data = 16'hC96A;
        @(posedge clk); #1;
        obs = {gnt, done, sr_load, sr_shift, sr_d, busy};
        vectors++;
        if (obs !== 15'd0) begin
            miscompares++;
            $display("FAIL contention_in_reset: got %h required %h", obs, 15'd0);
        end
        rst = 1'b0;
        for (int t = 0; t < 5; t++) begin
            g = t % 4;
            for (int k = 0; k < 7; k++) begin
                @(posedge clk); #1;
                obs = {gnt, done, sr_load, sr_shift, sr_d, busy};
                exp = exp_vec(4'b0001 << g, dv[g], k, 1);
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL contention t%0d k%0d: got %h required %h", t, k, obs, exp);
                end
                if (t == 4 && k == 5) req = 4'b0000;
            end
        end
    endtask

    task automatic test_pointer_wrap();
        logic [3:0]  gseq [3];
        logic [3:0]  dseq [3];
        logic [14:0] obs;
        logic [14:0] exp;
        gseq = '{4'b1000, 4'b0001, 4'b1000};
        dseq = '{4'h5, 4'h7, 4'h5};
        req      = 4'b1000;
        req_data = 16'h5007;
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 7; k++) begin
                @(posedge clk); #1;
                obs = {gnt, done, sr_load, sr_shift, sr_d, busy};
                exp = exp_vec(gseq[t], dseq[t], k, 1);
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL pointer_wrap t%0d k%0d: got %h required %h", t, k, obs, exp);
                end
                if (t == 0 && k == 5) req = 4'b1001;
                if (t == 2 && k == 5) req = 4'b0000;
            end
        end
    endtask

    task automatic test_single();
        logic [14:0] obs;
        logic [14:0] exp;
        req      = 4'b0100;
        req_data = 16'h0A00;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            obs = {gnt, done, sr_load, sr_shift, sr_d, busy};
            exp = exp_vec(4'b0100, 4'hA, k, 1);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL single k%0d: got %h required %h", k, obs, exp);
            end
            if (k == 4) req = 4'b0000;
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [14:0] obs;
        logic [14:0] exp;
        req      = 4'b0100;
        req_data = 16'h0300;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            obs = {gnt, done, sr_load, sr_shift, sr_d, busy};
            exp = exp_vec(4'b0100, 4'h3, k, 1);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL rst_mid_pre k%0d: got %h required %h", k, obs, exp);
            end
        end
        rst = 1'b1;
        req = 4'b0000;
        @(posedge clk); #1;
        obs = {gnt, done, sr_load, sr_shift, sr_d, busy};
        vectors++;
        if (obs !== 15'd0) begin
            miscompares++;
            $display("FAIL rst_mid_cleared: got %h required %h", obs, 15'd0);
        end
        rst      = 1'b0;
        req      = 4'b0001;
        req_data = 16'h000E;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            obs = {gnt, done, sr_load, sr_shift, sr_d, busy};
            exp = exp_vec(4'b0001, 4'hE, k, 1);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL rst_mid_post k%0d: got %h required %h", k, obs, exp);
            end
            if (k == 5) req = 4'b0000;
        end
    endtask

    task automatic test_req_drop();
        logic [14:0] obs;
        logic [14:0] exp;
        req      = 4'b0010;
        req_data = 16'h0050;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            obs = {gnt, done, sr_load, sr_shift, sr_d, busy};
            exp = exp_vec(4'b0010, 4'h5, k, 1);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL req_drop k%0d: got %h required %h", k, obs, exp);
            end
            if (k == 1) begin
                req      = 4'b0000;
                req_data = 16'hFFFF;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  gseq [2];
        logic [3:0]  dseq [2];
        logic [14:0] obs;
        logic [14:0] exp;
        gseq = '{4'b0001, 4'b0010};
        dseq = '{4'h4, 4'hB};
        b_req      = 4'b0011;
        b_req_data = 16'h00B4;
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                obs = {b_gnt, b_done, b_sr_load, b_sr_shift, b_sr_d, b_busy};
                exp = exp_vec(gseq[t], dseq[t], k, 0);
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL back_to_back t%0d k%0d: got %h required %h", t, k, obs, exp);
                end
                if (t == 1 && k == 4) b_req = 4'b0000;
            end
        end
        @(posedge clk); #1;
        obs = {b_gnt, b_done, b_sr_load, b_sr_shift, b_sr_d, b_busy};
        exp = {4'd0, 4'd0, 1'b0, 1'b0, 4'hB, 1'b0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL back_to_back_idle: got %h required %h", obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req         = 4'b0000;
        req_data    = 16'h0000;
        b_req       = 4'b0000;
        b_req_data  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        fork
            monitor();
        join_none
        test_reset();
        test_contention();
        test_pointer_wrap();
        test_single();
        test_reset_mid_shift();
        test_req_drop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
